// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM and frame-result types plus active-low column drive patterns for keypad_scan
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;
  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return idx == 2'd0 ? COL0 : idx == 2'd1 ? COL1 : idx == 2'd2 ? COL2 : COL3;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-stage synchronizer; resets to all-ones so idle rows read as released
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad scanner with frame-based debounce; define KEYPAD_REPEAT_EN for auto-repeat while held
module keypad_scan #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  import keypad_pkg::*;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);
  logic [DW-1:0] div;
  logic          tick, frame_end, single;
  logic [1:0]    col_idx;
  logic [3:0]    row_s, hit, cnt, cnt_nxt, cand, cand_nxt, code_nxt, run, rel;
  logic [15:0]   acc, fv;
  logic [4:0]    ones;
  logic          held_nxt, valid_nxt;
  frame_t        res;
  state_t        state, state_nxt;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep, rep_nxt;
`endif

  keypad_sync #(.WIDTH(4)) u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .d        (row_in),
    .q        (row_s)
  );

  assign tick      = div == DW'(SCAN_DIV - 1);
  assign frame_end = tick && col_idx == 2'd3;
  assign col_out   = col_drive(col_idx);
  assign single    = res == SINGLE;
  assign run       = (state == DEBOUNCE && hit == cand) ? cnt : 4'd0;
  assign rel       = state == RELEASE ? cnt : 4'd0;

  // Frame vector: earlier columns from acc, current column straight from the synchronized rows
  always_comb begin
    fv   = acc;
    ones = '0;
    hit  = '0;
    for (int r = 0; r < 4; r++) fv[4 * r + int'(col_idx)] = ~row_s[r];
    for (int i = 0; i < 16; i++)
      if (fv[i]) begin
        ones = ones + 5'd1;
        hit  = 4'(i);
      end
    res = ones == 5'd0 ? NONE : ones == 5'd1 ? SINGLE : MULTI;
  end

  // MULTI frames fall through the !single paths, so they behave exactly like NONE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    held_nxt  = key_held;
    valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt   = rep;
`endif
    if (frame_end)
      case (state)
        IDLE, DEBOUNCE:
          if (!single) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (run == DB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            cand_nxt  = hit;
            code_nxt  = hit;
            held_nxt  = 1'b1;
            valid_nxt = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_nxt   = '0;
`endif
          end else begin
            state_nxt = DEBOUNCE;
            cand_nxt  = hit;
            cnt_nxt   = run + 4'd1;
          end
        default:
          if (single && hit == key_code) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_nxt   = (state == HELD && rep != RP_LAST) ? rep + 1'b1 : '0;
            valid_nxt = state == HELD && rep == RP_LAST;
`endif
          end else if (single) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
          end else if (rel == DB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            held_nxt  = 1'b0;
          end else begin
            state_nxt = RELEASE;
            cnt_nxt   = rel + 4'd1;
          end
      endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      div       <= '0;
      col_idx   <= '0;
      acc       <= '0;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      div       <= tick ? '0 : div + 1'b1;
      col_idx   <= tick ? col_idx + 2'd1 : col_idx;
      acc       <= tick ? (frame_end ? '0 : fv) : acc;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
      key_valid <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep       <= rep_nxt;
`endif
    end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000: sys_clk cycles per column slot; legal minimum 4.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive full frames needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_SCANS, default 50: frames between auto-repeat pulses; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 sys_clk  input  1  single clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 row_in  input  4  keypad rows, asynchronous, active-low (0 = pressed on the driven column).
REQ-007 col_out  output  4  column drive, active-low one-hot.
REQ-008 key_code  output  4  accepted key, row*4+col.
REQ-009 key_valid  output  1  one-cycle pulse on key acceptance (and on each repeat).
REQ-010 key_held  output  1  high from acceptance until release is accepted.

Function
REQ-011 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Divider SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be a one-cycle pulse at SCAN_DIV-1.
REQ-013 On tick, synchronized rows SHALL be sampled for the current column col_idx, then col_idx SHALL advance 0->1->2->3->0 and col_out SHALL be ~(1<<col_idx).
REQ-014 A frame SHALL end on the tick sampling column 3; its result is NONE (0 pressed), SINGLE(code) (exactly 1 pressed), or MULTI (>=2 pressed).
REQ-015 MULTI frames SHALL be treated as NONE by the state machine (ghosting guard).
REQ-016 FSM states IDLE, DEBOUNCE, HELD, RELEASE SHALL be evaluated only at frame end.
REQ-017 IDLE: SINGLE(c) -> DEBOUNCE, cand=c, cnt=1; else stay.
REQ-018 DEBOUNCE: SINGLE(cand) -> cnt+1; SINGLE(other) -> restart with cand=other, cnt=1; NONE -> IDLE, cnt=0.
REQ-019 DEBOUNCE with cnt reaching DEBOUNCE_SCANS -> HELD; key_code<=cand, key_held<=1, key_valid pulses in the cycle after that frame-end tick.
REQ-020 HELD: SINGLE(key_code) -> stay; anything else -> RELEASE, cnt=1 if NONE, else 0.
REQ-021 RELEASE: NONE -> cnt+1, reaching DEBOUNCE_SCANS -> IDLE, key_held<=0; SINGLE(key_code) -> HELD, no new key_valid; SINGLE(other) -> cnt=0, stay.
REQ-022 key_code SHALL hold its last accepted value after release.
REQ-023 With DEBOUNCE_SCANS=1, acceptance SHALL occur at the first SINGLE frame.

Reset
REQ-024 Asserting sys_rst_n low at any time, including mid-frame or in HELD, SHALL force: divider=0, col_idx=0, col_out=4'b1110, state=IDLE, all counters=0, key_code=0, key_valid=0, key_held=0, synchronizer=4'b1111.
REQ-025 After reset release, the first tick SHALL occur SCAN_DIV cycles later.

Configuration
REQ-026 Macro KEYPAD_REPEAT_EN defined: in HELD, a repeat counter SHALL pulse key_valid every REPEAT_SCANS frames; the counter clears on entering HELD.
REQ-027 Macro KEYPAD_REPEAT_EN undefined: key_valid SHALL pulse exactly once per accepted press, and no repeat logic is present.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state enum, the frame-result enum (NONE/SINGLE/MULTI), and the column one-hot constants.
REQ-029 The synchronizer SHALL be sub-module keypad_sync (parameterized width, 2 stages, reset to all-ones).

Verification (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2; frame = 16 cycles)
REQ-030 Row 2 low while column 1 is driven, held for 5 frames -> key_code=9, one key_valid pulse after the 3rd frame end, key_held=1.
REQ-031 Same key pressed for 2 frames, then released -> no key_valid, key_held stays 0.
REQ-032 Keys 0 and 5 pressed together for 6 frames -> no key_valid (MULTI).
REQ-033 Key 9 held, then released -> key_held falls after the 3rd NONE frame end; a 1-frame release glitch mid-hold leaves key_held=1 with no extra key_valid.
REQ-034 sys_rst_n pulsed low mid-cycle while in HELD -> all outputs at reset values immediately, col_out=4'b1110.
REQ-035 KEYPAD_REPEAT_EN defined, key 9 held for 9 frames -> key_valid at frame 3, then at frames 5, 7 and 9.
